// File: rtl/param_univ_shift_reg.sv
// Parametrised universal register: hold, load, shift, rotate, up/down count.
// Single state element Q; all other outputs are combinational from Q, en, mode.
module param_univ_shift_reg #(
  parameter int unsigned      WIDTH   = 8,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [2:0]       mode,
  input  logic [WIDTH-1:0] D,
  input  logic             sin_l,
  input  logic             sin_r,
  output logic [WIDTH-1:0] Q,
  output logic [WIDTH-1:0] Qb,
  output logic             sout_l,
  output logic             sout_r,
  output logic             tc
);

  localparam logic [WIDTH-1:0] ONES = '1;
  localparam logic [WIDTH-1:0] ZERO = '0;
  localparam logic [WIDTH-1:0] ONE  = WIDTH'(1);

  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] q_nxt;

  always_comb begin
    q_nxt = q;
    unique case (mode)
      3'b000: q_nxt = q;
      3'b001: q_nxt = D;
      3'b010: q_nxt = {q[WIDTH-2:0], sin_r};
      3'b011: q_nxt = {sin_l, q[WIDTH-1:1]};
      3'b100: q_nxt = {q[WIDTH-2:0], q[WIDTH-1]};
      3'b101: q_nxt = {q[0], q[WIDTH-1:1]};
      3'b110: q_nxt = q + ONE;
      3'b111: q_nxt = q - ONE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst)     q <= RST_VAL;
    else if (en) q <= q_nxt;
  end

  assign Q      = q;
  assign Qb     = ~q;
  assign sout_l = q[WIDTH-1];
  assign sout_r = q[0];

  // Carry-out for cascading: high only on the edge that will wrap.
  assign tc = en & (((mode == 3'b110) & (q == ONES)) |
                    ((mode == 3'b111) & (q == ZERO)));

endmodule

// File: tb/tb_param_univ_shift_reg.sv
// Bench for param_univ_shift_reg: WIDTH=8, RST_VAL=A5, 600 ns clock.
// Expected Q values are queued with stimulus and popped after each edge.
module tb_param_univ_shift_reg;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       en = 1'b0;
  logic [2:0] mode = 3'b000;
  logic [7:0] D = 8'h00;
  logic       sin_l = 1'b0;
  logic       sin_r = 1'b0;
  logic [7:0] Q, Qb;
  logic       sout_l, sout_r, tc;

  logic [7:0] hq, hqb;
  logic       hsl, hsr, htc;

  int vectors = 0;
  int miscompares = 0;
  logic [7:0] exp_q[$];
  logic [7:0] e;

  always #300 clk = ~clk;

  param_univ_shift_reg #(.WIDTH(8), .RST_VAL(8'hA5)) dut (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .D(D),
    .sin_l(sin_l), .sin_r(sin_r), .Q(Q), .Qb(Qb),
    .sout_l(sout_l), .sout_r(sout_r), .tc(tc)
  );

  param_univ_shift_reg #(.WIDTH(8), .RST_VAL(8'h00)) hi (
    .clk(clk), .rst(rst), .en(tc), .mode(3'b110), .D(8'h00),
    .sin_l(1'b0), .sin_r(1'b0), .Q(hq), .Qb(hqb),
    .sout_l(hsl), .sout_r(hsr), .tc(htc)
  );

  task automatic drive(input logic r, input logic e_in,
                       input logic [2:0] m, input logic [7:0] d,
                       input logic sl, input logic sr);
    @(negedge clk);
    rst = r; en = e_in; mode = m; D = d; sin_l = sl; sin_r = sr;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    drive(1'b1, 1'b1, 3'b110, 8'h3C, 1'b1, 1'b1);
    exp_q.push_back(8'hA5);
    tick();
    e = exp_q.pop_front();
    vectors++;
    if (Q !== e) begin
      miscompares++;
      $display("FAIL reset_q got=%h exp=%h", Q, e);
    end
    vectors++;
    if (Qb !== 8'h5A) begin
      miscompares++;
      $display("FAIL reset_qb got=%h exp=5a", Qb);
    end
    vectors++;
    if ({sout_l, sout_r, tc} !== 3'b110) begin
      miscompares++;
      $display("FAIL reset_sout_tc got=%b exp=110", {sout_l, sout_r, tc});
    end
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 1'b0, 3'b001, 8'hFF, 1'b0, 1'b0);
      exp_q.push_back(8'hA5);
      tick();
      e = exp_q.pop_front();
      vectors++;
      if (Q !== e) begin
        miscompares++;
        $display("FAIL en_low_hold%0d got=%h exp=%h", i, Q, e);
      end
    end
  endtask

  task automatic test_load_edge();
    drive(1'b0, 1'b1, 3'b001, 8'h3C, 1'b0, 1'b0);
    exp_q.push_back(8'h3C);
    tick();
    e = exp_q.pop_front();
    vectors++;
    if (Q !== e) begin
      miscompares++;
      $display("FAIL load got=%h exp=%h", Q, e);
    end
    for (int i = 0; i < 7; i++) begin
      #75;
      D = ~D;
      #0;
      vectors++;
      if (Q !== e) begin
        miscompares++;
        $display("FAIL load_midcycle%0d got=%h exp=%h", i, Q, e);
      end
    end
    en = 1'b0;
  endtask

  task automatic test_shift_rotate();
    logic [2:0] m_t[7] = '{3'b001, 3'b010, 3'b011, 3'b001,
                           3'b100, 3'b001, 3'b101};
    logic [7:0] x_t[7] = '{8'h81, 8'h03, 8'h01, 8'h81,
                           8'h03, 8'h81, 8'hC0};
    for (int i = 0; i < 7; i++) begin
      drive(1'b0, 1'b1, m_t[i], 8'h81, 1'b0, 1'b1);
      exp_q.push_back(x_t[i]);
      tick();
      e = exp_q.pop_front();
      vectors++;
      if (Q !== e || Qb !== ~e) begin
        miscompares++;
        $display("FAIL shrot%0d got=%h/%h exp=%h", i, Q, Qb, e);
      end
      vectors++;
      if (sout_l !== e[7] || sout_r !== e[0]) begin
        miscompares++;
        $display("FAIL sout%0d got=%b%b exp=%b%b",
                 i, sout_l, sout_r, e[7], e[0]);
      end
    end
  endtask

  task automatic test_count_wrap();
    logic [7:0] x_t[3] = '{8'hFF, 8'h00, 8'hFF};
    logic       t_t[3] = '{1'b1, 1'b0, 1'b0};
    drive(1'b0, 1'b1, 3'b001, 8'hFE, 1'b0, 1'b0);
    exp_q.push_back(8'hFE);
    tick();
    e = exp_q.pop_front();
    vectors++;
    if (Q !== e) begin
      miscompares++;
      $display("FAIL cnt_load got=%h exp=%h", Q, e);
    end
    drive(1'b0, 1'b1, 3'b110, 8'h00, 1'b0, 1'b0);
    vectors++;
    if (tc !== 1'b0) begin
      miscompares++;
      $display("FAIL tc_fe got=%b exp=0", tc);
    end
    for (int i = 0; i < 3; i++) begin
      if (i == 2) begin
        drive(1'b0, 1'b1, 3'b111, 8'h00, 1'b0, 1'b0);
        vectors++;
        if (tc !== 1'b1) begin
          miscompares++;
          $display("FAIL tc_down_zero got=%b exp=1", tc);
        end
      end
      exp_q.push_back(x_t[i]);
      tick();
      e = exp_q.pop_front();
      vectors++;
      if (Q !== e || tc !== t_t[i]) begin
        miscompares++;
        $display("FAIL wrap%0d got=%h tc=%b exp=%h tc=%b",
                 i, Q, tc, e, t_t[i]);
      end
    end
  endtask

  task automatic test_reset_mid_count();
    logic [7:0] x_t[6] = '{8'h10, 8'h11, 8'h12, 8'h13, 8'hA5, 8'hA6};
    drive(1'b0, 1'b1, 3'b001, 8'h10, 1'b0, 1'b0);
    for (int i = 0; i < 7; i++) begin
      if (i == 1) drive(1'b0, 1'b1, 3'b110, 8'h00, 1'b0, 1'b0);
      if (i == 4) drive(1'b1, 1'b1, 3'b110, 8'h00, 1'b0, 1'b0);
      if (i == 5) drive(1'b0, 1'b1, 3'b110, 8'h00, 1'b0, 1'b0);
      exp_q.push_back(i < 6 ? x_t[i] : 8'hA7);
      tick();
      e = exp_q.pop_front();
      vectors++;
      if (Q !== e) begin
        miscompares++;
        $display("FAIL rst_mid%0d got=%h exp=%h", i, Q, e);
      end
    end
  endtask

  task automatic test_cascade();
    drive(1'b1, 1'b0, 3'b000, 8'h00, 1'b0, 1'b0);
    tick();
    drive(1'b0, 1'b1, 3'b001, 8'h00, 1'b0, 1'b0);
    tick();
    vectors++;
    if (Q !== 8'h00 || hq !== 8'h00) begin
      miscompares++;
      $display("FAIL casc_init got=%h%h exp=0000", hq, Q);
    end
    drive(1'b0, 1'b1, 3'b110, 8'h00, 1'b0, 1'b0);
    for (int k = 1; k <= 520; k++) begin
      exp_q.push_back(8'(k / 256));
      tick();
      e = exp_q.pop_front();
      vectors++;
      if (hq !== e || Q !== 8'(k)) begin
        miscompares++;
        $display("FAIL cascade%0d got=%h%h exp=%h%h",
                 k, hq, Q, e, 8'(k));
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_load_edge();
    test_shift_rotate();
    test_count_wrap();
    test_reset_mid_count();
    test_cascade();
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
